// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN datapath blocks.
package cnn_pkg;

    localparam int DEF_BIT_SIZE = 8;
    localparam int DEF_TAPS     = 9;

    // Window controller states; the encoding is fixed so that state dumps
    // read the same across the datapath blocks.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Ceiling log2, for sizing counters and accumulators from parameters.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mult_param.sv
// Registered signed multiplier: product and done update one edge after en.
module mult_param
    import cnn_pkg::*;
#(
    parameter int BIT_SIZE = DEF_BIT_SIZE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic signed [BIT_SIZE-1:0]   a,
    input  logic signed [BIT_SIZE-1:0]   b,
    output logic signed [2*BIT_SIZE-1:0] product,
    output logic                         done
);

    logic signed [2*BIT_SIZE-1:0] product_q, product_d;
    logic                         done_q, done_d;

    // Next product is taken only when enabled; done mirrors en one edge later.
    always_comb begin
        product_d = product_q;
        done_d    = en;
        if (en) begin
            product_d = a * b;
        end
    end

    // Product register with synchronous reset.
    // NOTE: this reset is synchronous, so an asynchronous reset pulse that sees
    // no clock edge leaves product_q stale; consumers must qualify it themselves.
    always_ff @(posedge clk) begin
        if (reset) begin
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign product = product_q;
    assign done    = done_q;

endmodule

// File: rtl/conv_mac_ctrl.sv
// Convolution window MAC controller: reads TAPS pixel/weight pairs from
// synchronous-read buffers, accumulates bias + sum(pixel*weight) through one
// shared registered multiplier, applies optional ReLU and hands the result off
// with valid/ready. Each accepted start is followed by TAPS+4 busy cycles; the
// handshake edge returns to IDLE and the following edge can accept a new start.
module conv_mac_ctrl
    import cnn_pkg::*;
#(
    parameter int BIT_SIZE = DEF_BIT_SIZE,
    parameter int TAPS     = DEF_TAPS,
    parameter int ADDR_W   = 4,
    parameter int ACC_W    = 2*BIT_SIZE + 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic signed [ACC_W-1:0]    bias,
    input  logic                       relu_en,
    output logic                       busy,
    output logic                       rd_en,
    output logic [ADDR_W-1:0]          rd_addr,
    input  logic signed [BIT_SIZE-1:0] pix_data,
    input  logic signed [BIT_SIZE-1:0] wgt_data,
    output logic signed [ACC_W-1:0]    result,
    output logic                       result_valid,
    input  logic                       result_ready
);

    localparam int                PROD_W    = 2*BIT_SIZE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TAPS - 1);

    state_t                    state_q, state_d;
    logic                      rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]         rd_addr_q, rd_addr_d;
    logic                      mul_en_q, mul_en_d;
    logic                      acc_en_q, acc_en_d;
    logic                      relu_q, relu_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   result_q, result_d;
    logic                      result_valid_q, result_valid_d;

    logic signed [PROD_W-1:0]  product;
    logic signed [ACC_W-1:0]   product_ext;
    logic                      mult_done_unused;

    // The multiplier fires one cycle after each read, when buffer data is valid.
    mult_param #(
        .BIT_SIZE (BIT_SIZE)
    ) u_mult (
        .clk     (clk),
        .reset   (reset),
        .en      (mul_en_q),
        .a       (pix_data),
        .b       (wgt_data),
        .product (product),
        .done    (mult_done_unused)
    );

    assign product_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};

    // Next-state, read sequencing, accumulation and result capture.
    // NOTE: every _d gets its hold value first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        rd_en_d        = rd_en_q;
        rd_addr_d      = rd_addr_q;
        relu_d         = relu_q;
        acc_d          = acc_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        mul_en_d       = rd_en_q;
        acc_en_d       = mul_en_q;

        // acc_en_q, not the multiplier's done, qualifies the product: done is
        // only cleared on a clock edge and can be stale after an async reset.
        if (acc_en_q) begin
            acc_d = acc_q + product_ext;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    acc_d     = bias;
                    relu_d    = relu_en;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                end
            end
            RUN: begin
                if (rd_addr_q == LAST_ADDR) begin
                    state_d   = DRAIN;
                    rd_en_d   = 1'b0;
                    rd_addr_d = '0;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                // Both pipeline flags low means the last product is in acc_q.
                if (!mul_en_q && !acc_en_q) begin
                    state_d        = DONE;
                    result_valid_d = 1'b1;
                    result_d       = (relu_q && acc_q[ACC_W-1]) ? '0 : acc_q;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d        = IDLE;
                    result_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any window in flight.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            rd_en_q        <= 1'b0;
            rd_addr_q      <= '0;
            mul_en_q       <= 1'b0;
            acc_en_q       <= 1'b0;
            relu_q         <= 1'b0;
            acc_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_en_q        <= rd_en_d;
            rd_addr_q      <= rd_addr_d;
            mul_en_q       <= mul_en_d;
            acc_en_q       <= acc_en_d;
            relu_q         <= relu_d;
            acc_q          <= acc_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_conv_mac_ctrl.sv
// Self-checking bench for conv_mac_ctrl: directed windows from the test plan
// plus randomized windows checked against a plain-arithmetic dot-product model.
module tb_conv_mac_ctrl;

    localparam int BIT_SIZE = 8;
    localparam int TAPS     = 9;
    localparam int ADDR_W   = 4;
    localparam int ACC_W    = 2*BIT_SIZE + 4;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       start;
    logic signed [ACC_W-1:0]    bias;
    logic                       relu_en;
    logic                       busy;
    logic                       rd_en;
    logic [ADDR_W-1:0]          rd_addr;
    logic signed [BIT_SIZE-1:0] pix_data;
    logic signed [BIT_SIZE-1:0] wgt_data;
    logic signed [ACC_W-1:0]    result;
    logic                       result_valid;
    logic                       result_ready;

    logic signed [BIT_SIZE-1:0] pix_mem [TAPS];
    logic signed [BIT_SIZE-1:0] wgt_mem [TAPS];
    int                         addr_log [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_mac_ctrl #(
        .BIT_SIZE (BIT_SIZE),
        .TAPS     (TAPS),
        .ADDR_W   (ADDR_W),
        .ACC_W    (ACC_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bias         (bias),
        .relu_en      (relu_en),
        .busy         (busy),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .pix_data     (pix_data),
        .wgt_data     (wgt_data),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    // Synchronous-read pixel/weight buffers.
    always @(posedge clk) begin
        if (rd_en && int'(rd_addr) < TAPS) begin
            pix_data <= pix_mem[int'(rd_addr)];
            wgt_data <= wgt_mem[int'(rd_addr)];
        end
    end

    // Record every address the DUT reads, one entry per read cycle.
    always @(negedge clk) begin
        if (rd_en) addr_log.push_back(int'(rd_addr));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: bias plus the dot product of the buffers, then optional ReLU.
    function automatic logic signed [ACC_W-1:0] model(input int b, input bit relu);
        longint s;
        s = longint'(b);
        for (int k = 0; k < TAPS; k++) begin
            s += longint'(pix_mem[k]) * longint'(wgt_mem[k]);
        end
        if (relu && s < 0) s = 0;
        return ACC_W'(s);
    endfunction

    task automatic fill(input int p, input int w);
        for (int k = 0; k < TAPS; k++) begin
            pix_mem[k] = BIT_SIZE'(p);
            wgt_mem[k] = BIT_SIZE'(w);
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < TAPS; k++) begin
            pix_mem[k] = BIT_SIZE'($urandom);
            wgt_mem[k] = BIT_SIZE'($urandom);
        end
    endtask

    function automatic int rand_bias();
        return int'($urandom_range(0, 200000)) - 100000;
    endfunction

    // Present start for one edge; returns at the negedge after the accept edge.
    task automatic launch(input int b, input bit relu);
        @(negedge clk);
        bias    = ACC_W'(b);
        relu_en = relu;
        start   = 1'b1;
        addr_log.delete();
        @(negedge clk);
        start = 1'b0;
        check("start_accept_busy", busy, 1);
    endtask

    // Counts edges after the accept edge until result_valid (bounded).
    task automatic wait_result(output int lat);
        lat = 0;
        while (!result_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_reads(input string tag);
        bit ok;
        ok = (addr_log.size() == TAPS);
        for (int i = 0; i < TAPS && ok; i++) begin
            if (addr_log[i] != i) ok = 1'b0;
        end
        check({tag, "_rd_seq"}, ok, 1);
    endtask

    task automatic handshake(input string tag);
        logic signed [ACC_W-1:0] held;
        held         = result;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check({tag, "_valid_cleared"}, result_valid, 0);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_result_held"}, result, held);
    endtask

    task automatic run_window(input string tag, input int b, input bit relu,
                              input logic signed [ACC_W-1:0] exp);
        int lat;
        launch(b, relu);
        wait_result(lat);
        check({tag, "_latency"}, lat, TAPS + 3);
        check({tag, "_result"}, result, exp);
        check_reads(tag);
        handshake(tag);
    endtask

    // Two windows with start and result_ready held high; the second window's
    // data and bias are loaded once the first window's reads are finished.
    task automatic back_to_back();
        int                      ba, bb;
        bit                      ra, rb;
        logic signed [ACC_W-1:0] ea, eb, got_a, got_b;
        int                      r1, r2;
        bit                      have_a, have_b, prev_busy;
        r1 = -1; r2 = -1; have_a = 0; have_b = 0; prev_busy = 0;
        eb = '0; got_a = 'x; got_b = 'x;
        @(negedge clk);
        fill_rand();
        ba = rand_bias();
        ra = 1'($urandom_range(0, 1));
        ea = model(ba, ra);
        bias         = ACC_W'(ba);
        relu_en      = ra;
        start        = 1'b1;
        result_ready = 1'b1;
        for (int n = 1; n <= 80 && !have_b; n++) begin
            @(negedge clk);
            if (busy && !prev_busy) begin
                if (r1 < 0) r1 = n;
                else if (r2 < 0) begin
                    r2    = n;
                    start = 1'b0;
                end
            end
            prev_busy = busy;
            if (result_valid) begin
                if (!have_a) begin
                    have_a = 1'b1;
                    got_a  = result;
                    fill_rand();
                    bb      = rand_bias();
                    rb      = 1'($urandom_range(0, 1));
                    eb      = model(bb, rb);
                    bias    = ACC_W'(bb);
                    relu_en = rb;
                end else begin
                    have_b = 1'b1;
                    got_b  = result;
                end
            end
        end
        start = 1'b0;
        @(negedge clk);
        result_ready = 1'b0;
        // Handshake edge returns to IDLE; the next edge accepts the held start.
        check("b2b_start_gap", r2 - r1, TAPS + 5);
        check("b2b_first_result", got_a, ea);
        check("b2b_second_result", got_b, eb);
        check("b2b_idle_after", busy, 0);
    endtask

    initial begin
        int                      lat;
        int                      n;
        int                      b;
        bit                      r;
        logic signed [ACC_W-1:0] e;

        reset        = 1'b1;
        start        = 1'b0;
        bias         = '0;
        relu_en      = 1'b0;
        result_ready = 1'b0;
        fill(0, 0);

        // Reset state.
        #1;
        check("rst_busy", busy, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_result", result, 0);
        check("rst_result_valid", result_valid, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // All ones: 9 taps of 1*1.
        fill(1, 1);
        run_window("ones", 0, 1'b0, 9);

        // Largest-magnitude products: 9 * 16384 fits without overflow.
        fill(-128, -128);
        run_window("max_mag", 0, 1'b0, 147456);

        // Negative sum with and without ReLU.
        fill(-1, 5);
        run_window("neg_norelu", 3, 1'b0, -42);

        // ReLU clamp, then hold DONE with ready low while start pulses.
        launch(3, 1'b1);
        wait_result(lat);
        check("relu_latency", lat, TAPS + 3);
        check("relu_result", result, 0);
        check_reads("relu");
        for (int i = 0; i < 5; i++) begin
            start = i[0];
            @(negedge clk);
            check("hold_result", result, 0);
            check("hold_valid", result_valid, 1);
            check("hold_no_read", rd_en, 0);
        end
        check("hold_no_new_addr", addr_log.size(), TAPS);
        fill_rand();
        b = rand_bias();
        r = 1'($urandom_range(0, 1));
        e = model(b, r);
        bias         = ACC_W'(b);
        relu_en      = r;
        start        = 1'b1;
        result_ready = 1'b1;
        addr_log.delete();
        @(negedge clk);
        result_ready = 1'b0;
        check("hs_start_ignored", busy, 0);
        check("hs_valid_cleared", result_valid, 0);
        check("hs_result_held", result, 0);
        @(negedge clk);
        start = 1'b0;
        check("hs_start_next_edge", busy, 1);
        wait_result(lat);
        check("hs_win_latency", lat, TAPS + 3);
        check("hs_win_result", result, e);
        check_reads("hs_win");
        handshake("hs_win");

        // Asynchronous reset in the middle of RUN, then a clean window.
        fill(7, 7);
        launch(1000, 1'b0);
        n = 0;
        while (rd_addr != ADDR_W'(4) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_addr4", rd_addr, 4);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_rd_en", rd_en, 0);
        check("abort_rd_addr", rd_addr, 0);
        check("abort_result", result, 0);
        check("abort_result_valid", result_valid, 0);
        #1 reset = 1'b0;
        fill(2, 3);
        run_window("after_abort", 0, 1'b0, 54);

        // Randomized windows.
        for (int i = 0; i < 4; i++) begin
            fill_rand();
            b = rand_bias();
            r = 1'($urandom_range(0, 1));
            run_window("rand", b, r, model(b, r));
        end

        back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
